// File: rtl/case_fold_unique_filter.sv
// ---------------------------------------------------------------------------
// case_fold_unique_filter
//
// Streaming de-duplicator for batches of 8-bit ASCII characters. Each item
// is keyed by its upper-case fold ('a'..'z' map onto 'A'..'Z'). Only the
// first item of each key within a batch is forwarded, in its original case.
// Later items with the same key are dropped. A batch ends on an accepted
// item with in_last=1. One CLEAR cycle follows, which empties the seen-key
// table and reports the number of forwarded items.
//
// Optional feature macro: UNIQ_DROP_CNT_EN
//   When defined, this adds output drop_cnt[15:0]. It holds the number of
//   duplicates dropped in the finished batch and is valid with batch_done.
//
// Parameters:
//   DEPTH : number of distinct keys held per batch (>= 2)
//   CW    : width of batch_uniq_cnt, derived as $clog2(DEPTH+1)
//
// Ports:
//   clk            : clock, rising edge
//   rst_n          : synchronous active-low reset
//   in_valid       : upstream item valid
//   in_ready       : filter accepts an item this cycle
//   in_data        : ASCII character
//   in_last        : item closes its batch
//   out_valid      : forwarded item valid
//   out_ready      : downstream accepts
//   out_data       : forwarded character, original case
//   batch_done     : one-cycle pulse (the CLEAR cycle) after a batch's last item
//   batch_uniq_cnt : items forwarded in the finished batch, valid with batch_done
//   ovf            : sticky, a miss arrived while the table was full
// ---------------------------------------------------------------------------
module case_fold_unique_filter #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          batch_done,
    output logic [CW-1:0] batch_uniq_cnt,
`ifdef UNIQ_DROP_CNT_EN
    output logic [15:0]   drop_cnt,
`endif
    output logic          ovf
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_CLEAR = 1'b1} state_t;

    // Upper-case fold: only the lower-case letter range moves, everything else is its own key.
    function automatic logic [7:0] fold_key(input logic [7:0] c);
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            fold_key = c - 8'h20;
        end else begin
            fold_key = c;
        end
    endfunction

    state_t          r_state;
    logic [7:0]      r_keys [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]   r_fill;      // entries used; entries fill strictly in order
    logic [CW-1:0]   r_cnt;       // items forwarded so far in the current batch
    logic [CW-1:0]   r_uniq;
    logic            r_done;
    logic            r_ovf;
    logic            r_out_valid;
    logic [7:0]      r_out_data;

    logic [7:0]      w_key;
    logic            w_hit;
    logic            w_full;
    logic            w_in_ready;
    logic            w_accept;
    logic            w_miss;
    logic [DEPTH-1:0] w_wr_sel;
    logic [CW-1:0]   w_cnt_nxt;

    // Handshake, table lookup and next-count computation.
    always_comb begin
        w_key      = fold_key(in_data);
        w_hit      = 1'b0;
        w_wr_sel   = '0;
        w_full     = (r_fill == CW'(DEPTH));
        w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
        w_accept   = in_valid && w_in_ready;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit = w_hit | (r_vld[i] && (r_keys[i] == w_key));
        end
        w_miss = w_accept && !w_hit;
        // The single free slot to write is the one indexed by the fill level.
        for (int i = 0; i < DEPTH; i++) begin
            w_wr_sel[i] = w_miss && !w_full && (r_fill == CW'(i));
        end
        if (w_miss && (r_cnt != {CW{1'b1}})) begin
            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Batch FSM, seen-key table, per-batch count and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_vld   <= '0;
            r_fill  <= '0;
            r_cnt   <= '0;
            r_uniq  <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_keys[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_done <= 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (w_wr_sel[i]) begin
                            r_keys[i] <= w_key;
                            r_vld[i]  <= 1'b1;
                        end
                    end
                    if (w_miss && !w_full) begin
                        r_fill <= r_fill + {{(CW-1){1'b0}}, 1'b1};
                    end
                    if (w_miss && w_full) begin
                        r_ovf <= 1'b1;
                    end
                    r_cnt <= w_cnt_nxt;
                    if (w_accept && in_last) begin
                        r_state <= ST_CLEAR;
                        r_done  <= 1'b1;
                        r_uniq  <= w_cnt_nxt;
                    end
                end
                ST_CLEAR: begin
                    r_vld   <= '0;
                    r_fill  <= '0;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: loads on a forwarded item, otherwise drains or holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else if (w_miss) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef UNIQ_DROP_CNT_EN
    logic [15:0] r_drop;
    logic [15:0] r_drop_out;
    logic [15:0] w_drop_nxt;

    // Saturating duplicate counter for the current batch.
    always_comb begin
        if (w_accept && w_hit && (r_drop != 16'hFFFF)) begin
            w_drop_nxt = r_drop + 16'd1;
        end else begin
            w_drop_nxt = r_drop;
        end
    end

    // Duplicate count bookkeeping, snapshot taken with the batch's last item.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop     <= 16'h0000;
            r_drop_out <= 16'h0000;
        end else if (r_state == ST_CLEAR) begin
            r_drop <= 16'h0000;
        end else begin
            r_drop <= w_drop_nxt;
            if (w_accept && in_last) begin
                r_drop_out <= w_drop_nxt;
            end
        end
    end

    assign drop_cnt = r_drop_out;
`endif

    assign in_ready       = w_in_ready;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign batch_done     = r_done;
    assign batch_uniq_cnt = r_uniq;
    assign ovf            = r_ovf;

endmodule
